// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock-enable divider with a free-running clkdiv bus.
// Each channel divides by a runtime-loaded divisor that takes effect at its next wrap.

module clkdiv_ch #(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             acc,
    input  logic [DIV_W-1:0] acc_div,
    output logic             tick,
    output logic             div_out,
    output logic             pending
);
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] cnt, div, shadow, de;
    logic             wrap;

    // a zero divisor behaves exactly like one
    assign de   = (div == '0) ? DIV_W'(1) : div;
    assign wrap = en && (cnt == de - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            div     <= DEF;
            shadow  <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                cnt     <= '0;
                div_out <= ~div_out;
                if (pending) begin
                    div     <= shadow;
                    pending <= 1'b0;
                end
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
            // acc only fires when not pending, so a same-cycle wrap never consumes it
            if (acc) begin
                shadow  <= acc_div;
                pending <= 1'b1;
            end
        end
    end
endmodule

module clkdiv_multi #(
    parameter int CNT_W   = 32,
    parameter int NCH     = 4,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 2,
    parameter int CH_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [CNT_W-1:0] clkdiv,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   div_out
);
    localparam int NSEL = 2**CH_W;

    logic [NCH-1:0]  pending;
    logic [NSEL-1:0] pend_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clkdiv <= '0;
        else      clkdiv <= clkdiv + 1'b1;
    end

    // unpopulated channel slots read as never pending, so their requests are swallowed
    assign pend_ext  = NSEL'(pending);
    assign cfg_ready = ~pend_ext[cfg_ch];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic acc;
        assign acc = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        clkdiv_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .acc    (acc),
            .acc_div(cfg_div),
            .tick   (tick[i]),
            .div_out(div_out[i]),
            .pending(pending[i])
        );
    end
endmodule

// File: tb/tb_clkdiv_multi.sv
// Randomized scoreboard bench for clkdiv_multi against an elapsed-cycle reference model.
module tb_clkdiv_multi;
    localparam int CNT_W = 32, NCH = 4, DIV_W = 16, DEF_DIV = 2, CH_W = 4;

    logic             clk, rst, en, cfg_valid, cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] clkdiv;
    logic [NCH-1:0]   tick, div_out;

    clkdiv_multi #(.CNT_W(CNT_W), .NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clkdiv(clkdiv), .tick(tick), .div_out(div_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [CNT_W-1:0] clkdiv;
        logic [NCH-1:0]   tick;
        logic [NCH-1:0]   div_out;
    } exp_t;

    exp_t exp_q[$];
    bit   rdy_q[$];
    int   n_chk = 0, n_fail = 0;

    // reference model: enabled cycles elapsed since the last tick, tick count parity gives div_out
    int unsigned      m_clk;
    int               m_div[NCH], m_shadow[NCH], m_el[NCH], m_nt[NCH];
    bit               m_pend[NCH];
    logic [NCH-1:0]   m_tick;

    task automatic chk(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_clk  = 0;
        m_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DEF_DIV; m_shadow[i] = 0; m_el[i] = 0; m_nt[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic model_step();
        bit acc;
        int ach, eff;
        acc = 0;
        ach = int'(cfg_ch);
        if (cfg_valid && ach < NCH) acc = !m_pend[ach];
        m_clk++;
        for (int i = 0; i < NCH; i++) begin
            eff = (m_div[i] == 0) ? 1 : m_div[i];
            m_tick[i] = en && (m_el[i] + 1 >= eff);
            if (m_tick[i]) begin
                m_nt[i]++;
                m_el[i] = 0;
                if (m_pend[i]) begin
                    m_div[i] = m_shadow[i];
                    m_pend[i] = 0;
                end
            end else if (en) begin
                m_el[i]++;
            end
        end
        if (acc) begin
            m_shadow[ach] = int'(cfg_div);
            m_pend[ach]   = 1;
        end
    endtask

    function automatic bit model_ready(input int ch);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    // one clock: advance model on the edge, queue expectations, then drive the next inputs
    task automatic cyc(input bit mid_rst, input bit n_rst, input bit n_en, input bit n_v,
                       input int n_ch, input int n_div);
        exp_t e;
        @(posedge clk);
        if (rst) model_step();
        if (mid_rst) begin
            #1 rst = 1'b0;
            #1;
            chk("async_rst_clkdiv", clkdiv, '0);
            chk("async_rst_tick", CNT_W'(tick), '0);
            chk("async_rst_divout", CNT_W'(div_out), '0);
            model_reset();
        end
        e.clkdiv = m_clk;
        e.tick   = m_tick;
        for (int i = 0; i < NCH; i++) e.div_out[i] = m_nt[i][0];
        exp_q.push_back(e);
        #1;
        rst       = n_rst;
        en        = n_en;
        cfg_valid = n_v;
        cfg_ch    = CH_W'(n_ch);
        cfg_div   = DIV_W'(n_div);
        rdy_q.push_back(model_ready(n_ch));
    endtask

    task automatic idle(input int n, input bit n_en);
        repeat (n) cyc(0, 1, n_en, 0, 0, 0);
    endtask

    // hold a request until the model says it was taken; bounded
    task automatic send(input int ch, input int d);
        int k = 0;
        bit took = 0;
        while (!took && k < 200) begin
            took = model_ready(ch);
            cyc(0, 1, 1, 1, ch, d);
            k++;
        end
        n_chk++;
        if (!took) begin
            n_fail++;
            $display("FAIL send_timeout ch%0d: not accepted after %0d cycles, required acceptance", ch, k);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("clkdiv", clkdiv, e.clkdiv);
                chk("tick", CNT_W'(tick), CNT_W'(e.tick));
                chk("div_out", CNT_W'(div_out), CNT_W'(e.div_out));
            end
            if (rdy_q.size() > 0) chk("cfg_ready", CNT_W'(cfg_ready), CNT_W'(rdy_q.pop_front()));
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        idle(12, 1);
        // mid-period load of ch1
        idle(1, 1);
        send(1, 5);
        idle(20, 1);
        // back-to-back to ch0, second one stalls
        send(0, 3);
        send(0, 7);
        idle(30, 1);
        // zero and one divisors
        send(2, 0);
        idle(10, 1);
        send(2, 1);
        idle(10, 1);
        // freeze with en low
        send(3, 4);
        idle(9, 1);
        idle(10, 0);
        idle(12, 1);
        // reset with pending update, then an out-of-range channel
        send(1, 9);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, NCH, 5);
        idle(10, 1);
        // random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom % 300 == 0) begin
                cyc(1, 0, 1, 0, 0, 0);
                cyc(0, 1, 1, 0, 0, 0);
            end else begin
                cyc(0, 1, ($urandom % 8) != 0, ($urandom % 4) == 0,
                    $urandom_range(0, NCH + 1), $urandom_range(0, 9));
            end
        end
        idle(2, 1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
